// File: rtl/load_align.sv
// Load alignment unit: fetches one memory word per load request and returns the
// byte/half/word (or LWL/LWR partial word) aligned and extended for the merge stage.
module load_align (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  ltype,
  input  logic [31:0] addr,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] masked_data,
  output logic        lr_en,
  output logic [2:0]  lrmux
);

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LWL = 3'b010;
  localparam logic [2:0] LT_LW  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;
  localparam logic [2:0] LT_LWR = 3'b110;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  ltype_reg;
  logic [31:0] addr_reg;
  logic        legal;
  logic        accept;
  logic        capture;
  logic [31:0] aligned;
  logic [31:0] lane_shift;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [1:0]  k;

  // Legality is judged on the incoming request, before it is registered.
  always_comb begin
    legal = 1'b1;
    if (ltype == 3'b111) legal = 1'b0;
    if ((ltype == LT_LH || ltype == LT_LHU) && addr[0]) legal = 1'b0;
    if (ltype == LT_LW && addr[1:0] != 2'b00) legal = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    capture     = 1'b0;
    mem_read    = 1'b0;
    mem_address = 32'h0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = legal ? REQ : DONE;
        end
      end
      REQ: begin
        busy        = 1'b1;
        mem_read    = 1'b1;
        mem_address = {addr_reg[31:2], 2'b00};
        if (!waitrequest) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Lane extraction from the word being captured this cycle.
  always_comb begin
    k          = addr_reg[1:0];
    lane_shift = readdata >> {k, 3'b000};
    byte_v     = lane_shift[7:0];
    half_v     = k[1] ? readdata[31:16] : readdata[15:0];
    aligned    = 32'h0;
    case (ltype_reg)
      LT_LB:   aligned = {{24{byte_v[7]}}, byte_v};
      LT_LBU:  aligned = {24'h0, byte_v};
      LT_LH:   aligned = {{16{half_v[15]}}, half_v};
      LT_LHU:  aligned = {16'h0, half_v};
      LT_LW:   aligned = readdata;
      LT_LWL:  aligned = readdata << {~k, 3'b000};
      LT_LWR:  aligned = lane_shift;
      default: aligned = 32'h0;
    endcase
  end

  // Result registers load only on entry to DONE, so they hold between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ltype_reg   <= 3'b000;
      addr_reg    <= 32'h0;
      err         <= 1'b0;
      masked_data <= 32'h0;
      lr_en       <= 1'b0;
      lrmux       <= 3'b000;
    end else if (accept) begin
      ltype_reg <= ltype;
      addr_reg  <= addr;
      if (!legal) begin
        err         <= 1'b1;
        masked_data <= 32'h0;
        lr_en       <= 1'b0;
        lrmux       <= 3'b000;
      end
    end else if (capture) begin
      err         <= 1'b0;
      masked_data <= aligned;
      lr_en       <= (ltype_reg == LT_LWL) || (ltype_reg == LT_LWR);
      lrmux       <= ((ltype_reg == LT_LWL) || (ltype_reg == LT_LWR)) ?
                     {ltype_reg == LT_LWR, k} : 3'b000;
    end
  end

endmodule

// File: tb/tb_load_align.sv
// Directed bench for load_align: a vector table of single loads with stalls,
// plus hand-written sequences for reset behaviour and result holding.
module tb_load_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  ltype;
  logic [31:0] addr;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] masked_data;
  logic        lr_en;
  logic [2:0]  lrmux;

  int checks = 0;
  int errors = 0;

  load_align dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ltype(ltype), .addr(addr),
    .mem_address(mem_address), .mem_read(mem_read), .waitrequest(waitrequest),
    .readdata(readdata), .busy(busy), .done(done), .err(err),
    .masked_data(masked_data), .lr_en(lr_en), .lrmux(lrmux)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  lt;
    logic [31:0] ad;
    logic [31:0] rd;
    int          stalls;
    logic        e;
    logic [31:0] md;
    logic        le;
    logic [2:0]  lm;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One load request: start pulsed in cycle 0, memory stalls for v.stalls REQ cycles.
  task automatic run(input int idx, input vec_t v);
    int stall_left;
    int reads;
    int done_cyc;
    logic addr_ok;
    logic [31:0] exp_ma;
    stall_left = v.stalls;
    reads      = 0;
    done_cyc   = -1;
    addr_ok    = 1'b1;
    exp_ma     = {v.ad[31:2], 2'b00};
    @(negedge clk);
    ltype = v.lt; addr = v.ad; readdata = v.rd; start = 1'b1; waitrequest = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (mem_read) begin
        reads++;
        if (mem_address !== exp_ma) addr_ok = 1'b0;
      end
      waitrequest = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      @(negedge clk);
    end
    waitrequest = 1'b0;
    check($sformatf("v%0d done_cycle", idx), done_cyc, v.e ? 1 : 2 + v.stalls);
    check($sformatf("v%0d read_cycles", idx), reads, v.e ? 0 : 1 + v.stalls);
    check($sformatf("v%0d mem_address", idx), {31'h0, addr_ok}, 32'h1);
    check($sformatf("v%0d err", idx), {31'h0, err}, {31'h0, v.e});
    check($sformatf("v%0d masked_data", idx), masked_data, v.md);
    check($sformatf("v%0d lr_en", idx), {31'h0, lr_en}, {31'h0, v.le});
    check($sformatf("v%0d lrmux", idx), {29'h0, lrmux}, {29'h0, v.lm});
    check($sformatf("v%0d busy_in_done", idx), {31'h0, busy}, 32'h1);
    check($sformatf("v%0d mem_addr_idle", idx), mem_address, 32'h0);
    @(negedge clk);
    check($sformatf("v%0d done_one_cycle", idx), {31'h0, done}, 32'h0);
    check($sformatf("v%0d hold_data", idx), masked_data, v.md);
    $display("txn %0d: ltype=%03b addr=0x%08h rd=0x%08h stalls=%0d -> err=%0b data=0x%08h lr_en=%0b lrmux=%03b",
             idx, v.lt, v.ad, v.rd, v.stalls, err, masked_data, lr_en, lrmux);
  endtask

  initial begin
    //          lt      addr          readdata      st err data          le lrmux
    vecs[0]  = '{3'b000, 32'h1003, 32'h80112233, 0, 0, 32'hFFFFFF80, 0, 3'b000};
    vecs[1]  = '{3'b101, 32'h2002, 32'hBEEF1234, 3, 0, 32'h0000BEEF, 0, 3'b000};
    vecs[2]  = '{3'b010, 32'h1001, 32'hAABBCCDD, 0, 0, 32'hCCDD0000, 1, 3'b001};
    vecs[3]  = '{3'b110, 32'h1003, 32'hAABBCCDD, 0, 0, 32'h000000AA, 1, 3'b111};
    vecs[4]  = '{3'b011, 32'h1002, 32'h12345678, 0, 1, 32'h00000000, 0, 3'b000};
    vecs[5]  = '{3'b100, 32'h1002, 32'h80112233, 1, 0, 32'h00000011, 0, 3'b000};
    vecs[6]  = '{3'b001, 32'h2000, 32'h12348001, 0, 0, 32'hFFFF8001, 0, 3'b000};
    vecs[7]  = '{3'b001, 32'h0011, 32'h12348001, 0, 1, 32'h00000000, 0, 3'b000};
    vecs[8]  = '{3'b011, 32'h4000, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 0, 3'b000};
    vecs[9]  = '{3'b111, 32'h4000, 32'hDEADBEEF, 0, 1, 32'h00000000, 0, 3'b000};
    vecs[10] = '{3'b010, 32'h5003, 32'hAABBCCDD, 0, 0, 32'hAABBCCDD, 1, 3'b011};
    vecs[11] = '{3'b110, 32'h5000, 32'hAABBCCDD, 2, 0, 32'hAABBCCDD, 1, 3'b100};
    vecs[12] = '{3'b100, 32'h1000, 32'h80112233, 0, 0, 32'h00000033, 0, 3'b000};

    rst_n = 1'b0; start = 1'b0; ltype = 3'b000; addr = 32'h0;
    waitrequest = 1'b0; readdata = 32'h0;
    #12;
    check("reset_outputs", {mem_address ^ masked_data, 24'h0, mem_read, busy, done, err, lr_en, lrmux},
          32'h0);
    check("reset_mem_address", mem_address, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run(i, vecs[i]);

    // Reset during a stalled REQ with start held high, then a fresh request.
    @(negedge clk);
    ltype = 3'b011; addr = 32'h3000; readdata = 32'h12345678; waitrequest = 1'b1; start = 1'b1;
    @(negedge clk);
    check("abort_req_active", {31'h0, mem_read}, 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_read_async", {31'h0, mem_read}, 32'h0);
    check("abort_busy_async", {31'h0, busy}, 32'h0);
    check("abort_mem_address", mem_address, 32'h0);
    @(negedge clk);
    check("abort_no_done", {31'h0, done}, 32'h0);
    rst_n = 1'b1; waitrequest = 1'b0;
    @(negedge clk);
    check("restart_mem_read", {31'h0, mem_read}, 32'h1);
    check("restart_mem_address", mem_address, 32'h3000);
    start = 1'b0;
    @(negedge clk);
    check("restart_done", {31'h0, done}, 32'h1);
    check("restart_data", masked_data, 32'h12345678);
    check("restart_err", {31'h0, err}, 32'h0);
    $display("txn reset-abort: restart LW 0x3000 -> done=%0b data=0x%08h", done, masked_data);

    // start while busy must be ignored: pulse during REQ, then expect idle after done.
    @(negedge clk);
    ltype = 3'b000; addr = 32'h6000; readdata = 32'h000000FF; start = 1'b1; waitrequest = 1'b1;
    @(negedge clk);
    ltype = 3'b111;
    @(negedge clk);
    start = 1'b0; waitrequest = 1'b0;
    @(negedge clk);
    check("busy_done", {31'h0, done}, 32'h1);
    check("busy_start_ignored_err", {31'h0, err}, 32'h0);
    check("busy_data", masked_data, 32'hFFFFFFFF);
    @(negedge clk);
    check("busy_back_idle", {30'h0, busy, mem_read}, 32'h0);
    $display("txn busy-ignore: LB 0x6000 -> data=0x%08h", masked_data);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_align.md
LOAD_ALIGN -- requirements
Module: load_align

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: `clk` and `rst_n`.
REQ-002 The ports SHALL be:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  load request, sampled in IDLE only
- `ltype`  in  3  load type: 000 LB, 001 LH, 010 LWL, 011 LW, 100 LBU, 101 LHU, 110 LWR, 111 reserved
- `addr`  in  32  effective byte address
- `mem_address`  out  32  word address to data memory
- `mem_read`  out  1  memory read strobe
- `waitrequest`  in  1  memory stall
- `readdata`  in  32  memory read word, byte lane k = bits [8k+7:8k]
- `busy`  out  1  high while a request is in flight
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  address or type error, valid with `done`
- `masked_data`  out  32  aligned/extended load data for the merge stage
- `lr_en`  out  1  high for LWL/LWR results
- `lrmux`  out  3  merge select: {is_lwr, addr[1:0]}

Function
REQ-003 The block SHALL implement a state machine with three states: IDLE, REQ and DONE.
REQ-004 In IDLE with `start`=1, the block SHALL register `ltype` and `addr`; it SHALL go to REQ if the request is legal and to DONE with `err`=1 otherwise.
REQ-005 A request SHALL be illegal for `ltype` 111, for LH/LHU with `addr[0]`=1, and for LW with `addr[1:0]`≠00.
REQ-006 An illegal request SHALL NOT assert `mem_read`, and its `masked_data` SHALL be zero.
REQ-007 In REQ, `mem_read` SHALL be 1 and `mem_address` SHALL be {addr[31:2], 2'b00}, both held stable while `waitrequest`=1.
REQ-008 In REQ, the first cycle with `waitrequest`=0 SHALL capture `readdata` and move to DONE.
REQ-009 A zero-wait access SHALL take start → done in 2 cycles, plus one cycle per stalled cycle.
REQ-010 In DONE, `done` SHALL be 1 for exactly one cycle, and the state SHALL return to IDLE.
REQ-011 `masked_data`, `lr_en`, `lrmux` and `err` SHALL update in DONE and hold until the next DONE.
REQ-012 `busy` SHALL be 1 in REQ and DONE, and `start` SHALL be ignored while `busy`=1.
REQ-013 Let k = `addr[1:0]`. LB/LBU SHALL return byte lane k, sign-extended for LB and zero-extended for LBU.
REQ-014 LH/LHU SHALL return lanes {k+1,k} as bits [15:0], sign-extended for LH and zero-extended for LHU.
REQ-015 LW SHALL return `readdata` unchanged.
REQ-016 LWL SHALL return `readdata` shifted left by 8*(3−k), zero-filled.
REQ-017 LWR SHALL return `readdata` shifted right by 8*k (logical).
REQ-018 `lr_en` SHALL be 1 only for LWL/LWR; `lrmux` SHALL be {ltype==LWR, k} for those types and 000 otherwise.
REQ-019 `mem_address` SHALL be zero whenever `mem_read`=0.

Reset
REQ-020 While `rst_n`=0, the block SHALL be in IDLE with every output zero, regardless of `clk`.
REQ-021 A reset asserted in REQ or DONE SHALL abort the request with no `done` pulse, and it SHALL take effect immediately.
REQ-022 After `rst_n` deasserts, the first `start` SHALL be accepted on the next rising edge.

Verification
REQ-023 LB at `addr`=0x1003, `readdata`=0x80112233, no stall → `done` on cycle 2, `masked_data`=0xFFFFFF80, `lr_en`=0.
REQ-024 LHU at 0x2002, `readdata`=0xBEEF1234, `waitrequest` high 3 cycles → `mem_address`=0x2000 held 4 cycles, `masked_data`=0x0000BEEF, `done` on cycle 5.
REQ-025 LWL at 0x1001, `readdata`=0xAABBCCDD → `masked_data`=0xCCDD0000, `lr_en`=1, `lrmux`=001.
REQ-026 LWR at 0x1003, `readdata`=0xAABBCCDD → `masked_data`=0x000000AA, `lrmux`=111.
REQ-027 LW at 0x1002 → `mem_read` never asserted, `done`=1 and `err`=1 on the next cycle, `masked_data`=0.
REQ-028 `rst_n` pulsed low mid-REQ with `waitrequest`=1, then `start`=1 held throughout → `mem_read` drops asynchronously, no `done` pulse, and a fresh request completes normally.
